// File: rtl/noc_tg_pkg.sv
// noc_tg_pkg: shared types and tdata field layout for the NoC traffic generator.
//   state_t : FSM state encoding. ST_GAP exists only when NOC_TG_GAP_EN is defined.
//   *_LSB / *_W : bit positions and widths of the fields in tdata[31:0].
package noc_tg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
`ifdef NOC_TG_GAP_EN
        ,
        ST_GAP  = 2'd3
`endif
    } state_t;

    // tdata[31:0] = {seq[15:0], 4'h0, router_address[3:0], idx[7:0]}
    localparam int IDX_LSB = 0;
    localparam int IDX_W   = 8;
    localparam int RTR_LSB = 8;
    localparam int RTR_W   = 4;
    localparam int RSV_LSB = 12;
    localparam int RSV_W   = 4;
    localparam int SEQ_LSB = 16;
    localparam int SEQ_W   = 16;

endpackage

// File: rtl/noc_tg_flit_gen.sv
// noc_tg_flit_gen: purely combinational flit builder. Its outputs feed the
// output registers in noc_traffic_generator.
// Ports:
//   seq            in  16      packet sequence number p
//   idx            in  8       flit index k within the packet
//   router_address in  4       source router id
//   dest_address   in  4       destination router id
//   tdata          out noc_dw  {p, 4'h0, router_address, k}, upper bits zero
//   tid/tdest/tuser out byte_dw zero-extended router id / dest id / p[7:0]
//   tlast          out 1       k == PKT_LEN-1
module noc_tg_flit_gen
    import noc_tg_pkg::*;
#(
    parameter int noc_dw  = 32,
    parameter int byte_dw = 8,
    parameter int PKT_LEN = 4
) (
    input  logic [SEQ_W-1:0]   seq,
    input  logic [IDX_W-1:0]   idx,
    input  logic [RTR_W-1:0]   router_address,
    input  logic [3:0]         dest_address,
    output logic [noc_dw-1:0]  tdata,
    output logic [byte_dw-1:0] tid,
    output logic [byte_dw-1:0] tdest,
    output logic [byte_dw-1:0] tuser,
    output logic               tlast
);

    always_comb begin
        tdata = '0;
        tdata[IDX_LSB +: IDX_W] = idx;
        tdata[RTR_LSB +: RTR_W] = router_address;
        tdata[RSV_LSB +: RSV_W] = '0;
        tdata[SEQ_LSB +: SEQ_W] = seq;
    end

    assign tid   = byte_dw'(router_address);
    assign tdest = byte_dw'(dest_address);
    assign tuser = byte_dw'(seq[7:0]);
    assign tlast = (idx == IDX_W'(PKT_LEN - 1));

endmodule

// File: rtl/noc_traffic_generator.sv
// noc_traffic_generator: AXI-Stream flit source that emits num_packets packets
// of PKT_LEN flits each towards dest_address.
// Build option: define NOC_TG_GAP_EN to insert one idle cycle (tvalid=0)
// after every non-final packet; without it packets go out back-to-back.
// Ports:
//   clk, reset (async, active-low), enable (level run request)
//   num_packets, dest_address : sampled when a run starts
//   router_address            : source id placed in tdata/tid
//   tready                    : sink ready
//   tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast : AXI-Stream master
//   pkt_count                 : packets completed in the current run
//   done                      : run finished, held while enable stays high
//
// state | meaning
// IDLE  | waiting for enable; starts a run (or goes straight to DONE if 0 packets)
// SEND  | tvalid=1, presenting flit (p, k); advances on tvalid & tready
// GAP   | one tvalid=0 cycle between packets (NOC_TG_GAP_EN only)
// DONE  | all packets sent, done=1 until enable drops
module noc_traffic_generator
    import noc_tg_pkg::*;
#(
    parameter int noc_dw  = 32,
    parameter int byte_dw = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [15:0]               num_packets,
    input  logic [3:0]                router_address,
    input  logic [3:0]                dest_address,
    input  logic                      tready,
    output logic                      tvalid,
    output logic [noc_dw-1:0]         tdata,
    output logic [noc_dw/byte_dw-1:0] tstrb,
    output logic [noc_dw/byte_dw-1:0] tkeep,
    output logic [byte_dw-1:0]        tid,
    output logic [byte_dw-1:0]        tdest,
    output logic [byte_dw-1:0]        tuser,
    output logic                      tlast,
    output logic [15:0]               pkt_count,
    output logic                      done
);

    state_t             state;
    logic               armed;
    logic [SEQ_W-1:0]   seq_q;
    logic [IDX_W-1:0]   idx_q;
    logic [15:0]        num_q;
    logic [3:0]         dest_q;

    logic [SEQ_W-1:0]   gen_seq;
    logic [IDX_W-1:0]   gen_idx;
    logic [3:0]         gen_dest;
    logic [noc_dw-1:0]  g_tdata;
    logic [byte_dw-1:0] g_tid;
    logic [byte_dw-1:0] g_tdest;
    logic [byte_dw-1:0] g_tuser;
    logic               g_tlast;
    logic               stall;

    assign tstrb = '1;
    assign tkeep = '1;

    // Flit to present after the next edge: the first flit of a run from IDLE,
    // the successor of the current flit in SEND, otherwise (p, k) as held.
    always_comb begin
        gen_seq  = seq_q;
        gen_idx  = idx_q;
        gen_dest = dest_q;
        case (state)
            ST_IDLE: begin
                gen_seq  = '0;
                gen_idx  = '0;
                gen_dest = dest_address;
            end
            ST_SEND: begin
                if (tlast) begin
                    gen_seq = seq_q + 16'd1;
                    gen_idx = '0;
                end else begin
                    gen_idx = idx_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Output payload registers only freeze while a flit is stalled; in every
    // other state tvalid qualifies them, so reloading them is harmless.
    assign stall = (state == ST_SEND) && !tready;

    noc_tg_flit_gen #(
        .noc_dw  (noc_dw),
        .byte_dw (byte_dw),
        .PKT_LEN (PKT_LEN)
    ) u_flit_gen (
        .seq            (gen_seq),
        .idx            (gen_idx),
        .router_address (router_address),
        .dest_address   (gen_dest),
        .tdata          (g_tdata),
        .tid            (g_tid),
        .tdest          (g_tdest),
        .tuser          (g_tuser),
        .tlast          (g_tlast)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            tvalid    <= 1'b0;
            tdata     <= '0;
            tid       <= '0;
            tdest     <= '0;
            tuser     <= '0;
            tlast     <= 1'b0;
            pkt_count <= '0;
            done      <= 1'b0;
            seq_q     <= '0;
            idx_q     <= '0;
            num_q     <= '0;
            dest_q    <= '0;
        end else begin
            // armed blocks leaving IDLE on the first edge after reset release
            armed <= 1'b1;

            if (!stall) begin
                tdata <= g_tdata;
                tid   <= g_tid;
                tdest <= g_tdest;
                tuser <= g_tuser;
                tlast <= g_tlast;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && armed) begin
                        num_q     <= num_packets;
                        dest_q    <= dest_address;
                        pkt_count <= '0;
                        seq_q     <= '0;
                        idx_q     <= '0;
                        if (num_packets == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= ST_SEND;
                            tvalid <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (tready) begin
                        seq_q <= gen_seq;
                        idx_q <= gen_idx;
                        if (tlast) begin
                            pkt_count <= pkt_count + 16'd1;
                            if (pkt_count == num_q - 16'd1) begin
                                state  <= ST_DONE;
                                tvalid <= 1'b0;
                                done   <= 1'b1;
                            end else if (!enable) begin
                                state  <= ST_IDLE;
                                tvalid <= 1'b0;
                            end
`ifdef NOC_TG_GAP_EN
                            else begin
                                state  <= ST_GAP;
                                tvalid <= 1'b0;
                            end
`endif
                        end
                    end
                end
`ifdef NOC_TG_GAP_EN
                ST_GAP: begin
                    state  <= ST_SEND;
                    tvalid <= 1'b1;
                end
`endif
                ST_DONE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tvalid <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_traffic_generator.sv
module tb_noc_traffic_generator;

    localparam int NOC_DW  = 32;
    localparam int BYTE_DW = 8;
    localparam int PKT_LEN = 4;
`ifdef NOC_TG_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] num_packets = '0;
    logic [3:0]  router_address = '0;
    logic [3:0]  dest_address = '0;
    logic        tready = 1'b0;
    logic               tvalid;
    logic [NOC_DW-1:0]  tdata;
    logic [NOC_DW/BYTE_DW-1:0] tstrb, tkeep;
    logic [BYTE_DW-1:0] tid, tdest, tuser;
    logic               tlast;
    logic [15:0]        pkt_count;
    logic               done;

    always #5 clk = ~clk;

    noc_traffic_generator #(.noc_dw(NOC_DW), .byte_dw(BYTE_DW), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk), .reset(reset), .enable(enable), .num_packets(num_packets),
        .router_address(router_address), .dest_address(dest_address), .tready(tready),
        .tvalid(tvalid), .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tid(tid),
        .tdest(tdest), .tuser(tuser), .tlast(tlast), .pkt_count(pkt_count), .done(done)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: packets completed (= current sequence number) and flit
    // index, advanced on every observed handshake.
    int          run_n = 0;
    bit          allow = 0;
    int          mdl_p = 0;
    int          mdl_k = 0;
    int          xfers = 0;
    int          tlast_cnt = 0;
    int          bubbles = 0;
    bit          seen_first = 0;
    logic [3:0]  mdl_dest = '0;
    logic [31:0] cap [0:15];
    logic [31:0] exp_td;
    bit          prev_stall = 0;
    logic [31:0] prev_td;
    logic        prev_tl;
    logic [7:0]  prev_tu;
    int          tready_mode = 0;
    int          pat_i = 0;

    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0: tready = 1'b1;
            1: begin
                tready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
                pat_i++;
            end
            default: tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) chk(tvalid, "stall_tvalid_held", 64'(tvalid), 64'd1);
            if (tvalid) begin
                if (!(allow && mdl_p < run_n)) begin
                    chk(1'b0, "unexpected_tvalid", 64'(tvalid), 64'd0);
                end else begin
                    exp_td = {mdl_p[15:0], 4'h0, router_address, mdl_k[7:0]};
                    chk(tdata == exp_td, "tdata", 64'(tdata), 64'(exp_td));
                    chk(tlast == (mdl_k == PKT_LEN - 1), "tlast", 64'(tlast), 64'(mdl_k == PKT_LEN - 1));
                    chk(tuser == mdl_p[7:0], "tuser", 64'(tuser), 64'(mdl_p[7:0]));
                    chk(tid == {4'h0, router_address}, "tid", 64'(tid), 64'(router_address));
                    chk(tdest == {4'h0, mdl_dest}, "tdest", 64'(tdest), 64'(mdl_dest));
                    chk(pkt_count == mdl_p[15:0], "pkt_count_live", 64'(pkt_count), 64'(mdl_p));
                    chk(tstrb == 4'hF && tkeep == 4'hF, "strb_keep", 64'({tstrb, tkeep}), 64'hFF);
                    if (prev_stall)
                        chk(tdata == prev_td && tlast == prev_tl && tuser == prev_tu, "stall_hold",
                            64'(tdata), 64'(prev_td));
                    if (tready) begin
                        if (xfers < 16) cap[xfers] = tdata;
                        xfers++;
                        if (tlast) tlast_cnt++;
                        mdl_k++;
                        if (mdl_k == PKT_LEN) begin
                            mdl_k = 0;
                            mdl_p++;
                        end
                    end
                    seen_first = 1;
                end
            end else if (allow && seen_first && mdl_p < run_n) begin
                bubbles++;
            end
            prev_stall = tvalid && !tready;
            prev_td = tdata;
            prev_tl = tlast;
            prev_tu = tuser;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic start_run(input int n, input logic [3:0] rtr, input logic [3:0] dst);
        @(posedge clk); #1;
        router_address = rtr;
        dest_address = dst;
        num_packets = 16'(n);
        mdl_dest = dst;
        mdl_p = 0; mdl_k = 0; xfers = 0; tlast_cnt = 0; bubbles = 0; seen_first = 0;
        run_n = n;
        allow = (n != 0);
        enable = 1'b1;
    endtask

    task automatic wait_pkts(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (mdl_p < n && i < budget) begin
            @(posedge clk); #2;
            i++;
        end
        if (mdl_p < n) chk(1'b0, name, 64'(mdl_p), 64'(n));
    endtask

    task automatic finish_run(input int n, input string name);
        chk(done == 1'b1, {name, "_done"}, 64'(done), 64'd1);
        chk(tvalid == 1'b0, {name, "_tvalid_off"}, 64'(tvalid), 64'd0);
        chk(pkt_count == 16'(n), {name, "_pkt_count"}, 64'(pkt_count), 64'(n));
        chk(xfers == n * PKT_LEN, {name, "_xfers"}, 64'(xfers), 64'(n * PKT_LEN));
        repeat (2) @(posedge clk);
        #2;
        chk(done == 1'b1, {name, "_done_persist"}, 64'(done), 64'd1);
        enable = 1'b0;
        @(posedge clk); #2;
        chk(done == 1'b0, {name, "_done_clear"}, 64'(done), 64'd0);
        allow = 0;
    endtask

    initial begin
        int i;
        #1 reset = 1'b0;
        #11;
        chk(tvalid == 0 && tlast == 0 && done == 0, "reset_ctrl", 64'({tvalid, tlast, done}), 64'd0);
        chk(tdata == 0 && tid == 0 && tdest == 0 && tuser == 0, "reset_data",
            64'({tdata, tid, tdest, tuser}), 64'd0);
        chk(pkt_count == 0, "reset_pkt_count", 64'(pkt_count), 64'd0);
        chk(tstrb == 4'hF && tkeep == 4'hF, "reset_strb_keep", 64'({tstrb, tkeep}), 64'hFF);
        @(negedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // two packets, always ready
        tready_mode = 0;
        start_run(2, 4'h5, 4'hA);
        wait_pkts(2, 40, "t1_timeout");
        chk(cap[5] == 32'h0001_0501, "t1_flit5", 64'(cap[5]), 64'h0001_0501);
        chk(cap[7] == 32'h0001_0503, "t1_flit7", 64'(cap[7]), 64'h0001_0503);
        chk(tlast_cnt == 2, "t1_tlast_cnt", 64'(tlast_cnt), 64'd2);
        chk(bubbles == GAP * 1, "t1_bubbles", 64'(bubbles), 64'(GAP));
        finish_run(2, "t1");

        // stalls with tready 1,0,0,1
        pat_i = 0;
        tready_mode = 1;
        start_run(3, 4'h3, 4'h7);
        wait_pkts(3, 200, "t2_timeout");
        finish_run(3, "t2");

        // enable dropped after flit 1 of packet 0
        tready_mode = 0;
        start_run(3, 4'h2, 4'h9);
        i = 0;
        while (xfers < 2 && i < 40) begin @(posedge clk); #2; i++; end
        chk(xfers == 2, "t3_reach_flit1", 64'(xfers), 64'd2);
        enable = 1'b0;
        run_n = mdl_p + 1;
        repeat (10) @(posedge clk);
        #2;
        chk(xfers == 4, "t3_packet_completed", 64'(xfers), 64'd4);
        chk(tlast_cnt == 1, "t3_tlast_seen", 64'(tlast_cnt), 64'd1);
        chk(pkt_count == 16'd1, "t3_pkt_count", 64'(pkt_count), 64'd1);
        chk(done == 1'b0, "t3_done_low", 64'(done), 64'd0);
        chk(tvalid == 1'b0, "t3_idle", 64'(tvalid), 64'd0);
        allow = 0;

        // zero packets
        start_run(0, 4'h1, 4'h1);
        @(posedge clk); #2;
        chk(done == 1'b1, "t4_done_next_cycle", 64'(done), 64'd1);
        chk(pkt_count == 16'd0, "t4_pkt_count", 64'(pkt_count), 64'd0);
        finish_run(0, "t4");

        // back-to-back (or gapped) three packets
        start_run(3, 4'hC, 4'h4);
        wait_pkts(3, 60, "t5_timeout");
        chk(bubbles == GAP * 2, "t5_bubbles", 64'(bubbles), 64'(GAP * 2));
        finish_run(3, "t5");

        // randomized runs with random backpressure
        tready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 5);
            start_run(n, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_pkts(n, 40 * n * PKT_LEN + 20, "t6_timeout");
            finish_run(n, "t6");
        end

        // reset mid-packet, then restart
        tready_mode = 0;
        start_run(3, 4'h6, 4'h1);
        i = 0;
        while (xfers < 2 && i < 40) begin @(posedge clk); #2; i++; end
        #2 reset = 1'b0;
        #1;
        chk(tvalid == 1'b0, "t7_async_tvalid", 64'(tvalid), 64'd0);
        chk(pkt_count == 16'd0 && tdata == 0, "t7_async_clear", 64'({pkt_count, tdata}), 64'd0);
        mdl_p = 0; mdl_k = 0; xfers = 0; tlast_cnt = 0; bubbles = 0; seen_first = 0;
        run_n = 3; allow = 1;
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #2;
        chk(tvalid == 1'b0, "t7_no_start_first_edge", 64'(tvalid), 64'd0);
        wait_pkts(3, 60, "t7_timeout");
        chk(cap[0] == 32'h0000_0600, "t7_restart_flit0", 64'(cap[0]), 64'h0000_0600);
        finish_run(3, "t7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
